// File: rtl/risc_pkg.sv
//------------------------------------------------------------------------------
// risc_pkg : shared widths and enums for the memory arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package risc_pkg;
  localparam int c_DATA_W = 16;
  localparam int c_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;
endpackage

`default_nettype wire

// File: rtl/risc_arb_pick.sv
//------------------------------------------------------------------------------
// risc_arb_pick : DM-priority winner select with IF starvation escape
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module risc_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_en,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_if_gnt,
  output logic o_dm_gnt
);
  localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;
  logic       w_if_win;

  assign w_if_win = i_if_req & (~i_dm_req | (r_starve == c_LIMIT));
  assign o_if_gnt = i_en & w_if_win;
  assign o_dm_gnt = i_en & i_dm_req & ~w_if_win;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_starve <= '0;
    end else if (o_if_gnt) begin
      r_starve <= '0;
    end else if (o_dm_gnt) begin
      if (!i_if_req)
        r_starve <= '0;
      else if (r_starve < c_LIMIT)
        r_starve <= r_starve + 4'd1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/risc_mem_arbiter.sv
//------------------------------------------------------------------------------
// risc_mem_arbiter : single-outstanding fetch/data arbiter onto one memory port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module risc_mem_arbiter
  import risc_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                HOLT,
  input  logic                IF_REQ,
  input  logic [c_ADDR_W-1:0] IF_ADDR,
  output logic                IF_GNT,
  output logic                IF_VALID,
  output logic [c_DATA_W-1:0] IF_RDATA,
  input  logic                DM_REQ,
  input  logic                DM_WE,
  input  logic [c_ADDR_W-1:0] DM_ADDR,
  input  logic [c_DATA_W-1:0] DM_WDATA,
  output logic                DM_GNT,
  output logic                DM_VALID,
  output logic [c_DATA_W-1:0] DM_RDATA,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [c_ADDR_W-1:0] MEM_ADDR,
  output logic [c_DATA_W-1:0] MEM_WDATA,
  input  logic                MEM_RDY,
  input  logic                MEM_RVALID,
  input  logic [c_DATA_W-1:0] MEM_RDATA
);
  arb_state_t          r_state;
  owner_t              r_owner;
  logic                r_we;
  logic [c_ADDR_W-1:0] r_addr;
  logic [c_DATA_W-1:0] r_wdata;
  logic                w_pick_en;

  // RST_N gates the combinational grants so every output is 0 during reset
  assign w_pick_en = (r_state == IDLE) & ~HOLT & RST_N;

  risc_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_en     (w_pick_en),
    .i_if_req (IF_REQ),
    .i_dm_req (DM_REQ),
    .o_if_gnt (IF_GNT),
    .o_dm_gnt (DM_GNT)
  );

  assign MEM_REQ   = (r_state == ISSUE);
  assign MEM_WE    = MEM_REQ & r_we;
  assign MEM_ADDR  = MEM_REQ ? r_addr  : '0;
  assign MEM_WDATA = MEM_REQ ? r_wdata : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_owner  <= OWN_IF;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      IF_VALID <= 1'b0;
      DM_VALID <= 1'b0;
      IF_RDATA <= '0;
      DM_RDATA <= '0;
    end else begin
      IF_VALID <= 1'b0;
      DM_VALID <= 1'b0;
      case (r_state)
        IDLE: begin
          if (IF_GNT | DM_GNT) begin
            r_owner <= DM_GNT ? OWN_DM : OWN_IF;
            r_we    <= DM_GNT & DM_WE;
            r_addr  <= DM_GNT ? DM_ADDR : IF_ADDR;
            r_wdata <= DM_GNT ? DM_WDATA : '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_RDY) begin
            if (r_we) begin
              DM_VALID <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (MEM_RVALID) begin
            if (r_owner == OWN_DM) begin
              DM_RDATA <= MEM_RDATA;
              DM_VALID <= 1'b1;
            end else begin
              IF_RDATA <= MEM_RDATA;
              IF_VALID <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire
